// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the IF/ID/EX sequencing controller.
package pipe_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int ADDR_W     = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    EX_WAIT  = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic flush_ifid;
    logic flush_idex;
    logic pc_load;
  } ctrl_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// Core status in, stall/flush/redirect controls and perf counters out.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic                  id_inst_valid_i;
  logic [REG_ADDR_W-1:0] id_reg1_raddr_i;
  logic [REG_ADDR_W-1:0] id_reg2_raddr_i;
  logic                  id_reg1_used_i;
  logic                  id_reg2_used_i;
  logic                  ex_load_i;
  logic [REG_ADDR_W-1:0] ex_reg_waddr_i;
  logic                  ex_jump_i;
  logic [ADDR_W-1:0]     ex_jump_addr_i;
  logic                  ex_busy_i;
  logic                  bus_wait_i;
  logic                  stall_pc_o;
  logic                  stall_ifid_o;
  logic                  stall_idex_o;
  logic                  flush_ifid_o;
  logic                  flush_idex_o;
  logic                  pc_load_o;
  logic [ADDR_W-1:0]     pc_load_addr_o;
  logic [1:0]            state_o;
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [CNT_W-1:0]      flush_cnt_o;

  modport master (
    output id_inst_valid_i, id_reg1_raddr_i, id_reg2_raddr_i, id_reg1_used_i,
           id_reg2_used_i, ex_load_i, ex_reg_waddr_i, ex_jump_i, ex_jump_addr_i,
           ex_busy_i, bus_wait_i,
    input  stall_pc_o, stall_ifid_o, stall_idex_o, flush_ifid_o, flush_idex_o,
           pc_load_o, pc_load_addr_o, state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_inst_valid_i, id_reg1_raddr_i, id_reg2_raddr_i, id_reg1_used_i,
           id_reg2_used_i, ex_load_i, ex_reg_waddr_i, ex_jump_i, ex_jump_addr_i,
           ex_busy_i, bus_wait_i,
    output stall_pc_o, stall_ifid_o, stall_idex_o, flush_ifid_o, flush_idex_o,
           pc_load_o, pc_load_addr_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     cnt_o <= '0;
    else if (inc_i && cnt_o != '1) cnt_o <= cnt_o + 1'b1;
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing FSM: load-use, EX-resolved jumps, multi-cycle EX and bus wait.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic        clk_i,
  input logic        rst_i,
  pipe_ctrl_if.slave bus
);
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl;
  logic       hazard;
  logic       run_rules, allow_hazard;

  assign hazard = bus.id_inst_valid_i & bus.ex_load_i & (bus.ex_reg_waddr_i != '0) &
                  ((bus.id_reg1_used_i & (bus.id_reg1_raddr_i == bus.ex_reg_waddr_i)) |
                   (bus.id_reg2_used_i & (bus.id_reg2_raddr_i == bus.ex_reg_waddr_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ctrl         = '0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_rules    = 1'b0;
    allow_hazard = 1'b0;
    case (state_q)
      RUN: begin
        run_rules    = 1'b1;
        allow_hazard = 1'b1;
      end
      LOAD_USE: run_rules = 1'b1;
      EX_WAIT: begin
        if (bus.ex_busy_i) begin
          ctrl.stall_pc   = 1'b1;
          ctrl.stall_ifid = 1'b1;
          ctrl.stall_idex = 1'b1;
        end else begin
          run_rules    = 1'b1;
          allow_hazard = 1'b1;
        end
      end
      FLUSH: begin
        ctrl.flush_ifid = 1'b1;
        ctrl.flush_idex = 1'b1;
        if (bus.bus_wait_i) begin
          ctrl.stall_pc = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= 4'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Shared priority chain; LOAD_USE runs it with the hazard term masked.
    if (run_rules) begin
      state_d = RUN;
      if (bus.ex_busy_i) begin
        ctrl.stall_pc   = 1'b1;
        ctrl.stall_ifid = 1'b1;
        ctrl.stall_idex = 1'b1;
        state_d         = EX_WAIT;
      end else if (bus.ex_jump_i) begin
        ctrl.pc_load    = 1'b1;
        ctrl.flush_ifid = 1'b1;
        ctrl.flush_idex = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end
      end else if (hazard && allow_hazard) begin
        ctrl.stall_pc   = 1'b1;
        ctrl.stall_ifid = 1'b1;
        ctrl.flush_idex = 1'b1;
        state_d         = LOAD_USE;
      end else if (bus.bus_wait_i) begin
        ctrl.stall_pc   = 1'b1;
        ctrl.stall_ifid = 1'b1;
        ctrl.stall_idex = 1'b1;
      end
    end

    if (rst_i) ctrl = '0;
  end

  assign bus.stall_pc_o     = ctrl.stall_pc;
  assign bus.stall_ifid_o   = ctrl.stall_ifid;
  assign bus.stall_idex_o   = ctrl.stall_idex;
  assign bus.flush_ifid_o   = ctrl.flush_ifid;
  assign bus.flush_idex_o   = ctrl.flush_idex;
  assign bus.pc_load_o      = ctrl.pc_load;
  assign bus.pc_load_addr_o = ctrl.pc_load ? bus.ex_jump_addr_i : '0;
  assign bus.state_o        = state_q;

  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_val;
  assign cnt_inc = {ctrl.pc_load, ctrl.stall_pc};

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (cnt_inc[g]),
      .cnt_o (cnt_val[g])
    );
  end

  assign bus.stall_cnt_o = cnt_val[0];
  assign bus.flush_cnt_o = cnt_val[1];
endmodule
